// File: rtl/ctrl_decode_pipe_if.sv
// D-stage instruction fields, hazard/flush controls and the registered EX control bundle.
// slave = decode unit side, master = pipeline / testbench side.
interface ctrl_decode_pipe_if #(
  parameter int ALUOP_W = 5
);
  logic               valid_d;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               stall_i;
  logic               flush_i;
  logic               stall_d_o;
  logic               mdu_start_o;
  logic               valid_e;
  logic               reg_write_e;
  logic               mem_write_e;
  logic               mem_to_reg_e;
  logic               pc_branch_e;
  logic [1:0]         srca_sel_e;
  logic [1:0]         srcb_sel_e;
  logic [ALUOP_W-1:0] alu_op_e;
  logic [2:0]         imm_sel_e;
  logic [2:0]         str_ctrl_e;
  logic               illegal_e;

  modport slave (
    input  valid_d, opcode, funct3, funct7, stall_i, flush_i,
    output stall_d_o, mdu_start_o, valid_e, reg_write_e, mem_write_e, mem_to_reg_e,
           pc_branch_e, srca_sel_e, srcb_sel_e, alu_op_e, imm_sel_e, str_ctrl_e, illegal_e
  );

  modport master (
    output valid_d, opcode, funct3, funct7, stall_i, flush_i,
    input  stall_d_o, mdu_start_o, valid_e, reg_write_e, mem_write_e, mem_to_reg_e,
           pc_branch_e, srca_sel_e, srcb_sel_e, alu_op_e, imm_sel_e, str_ctrl_e, illegal_e
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// RV32 D-stage control decode with ID/EX register, stall/flush bubbles and illegal flagging.
// Define RV32M_EN to add M-extension decode and the multicycle MUL/DIV sequencing FSM.
module ctrl_decode_pipe #(
  parameter int ALUOP_W    = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_decode_pipe_if.slave bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;

  if (MUL_CYCLES < 1 || DIV_CYCLES < 1 || (MAX_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cfg
    $error("ctrl_decode_pipe: cycle counts must be >=1 and fit in CNT_W");
  end

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_write;
    logic               mem_to_reg;
    logic               pc_branch;
    logic [1:0]         srca_sel;
    logic [1:0]         srcb_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic [2:0]         imm_sel;
    logic [2:0]         str_ctrl;
    logic               illegal;
  } ctrl_t;

  ctrl_t dec, ex_d, ex_q;
  logic  m_op;
  logic  stall_w, start_w;

  always_comb begin
    dec          = '0;
    m_op         = 1'b0;
    dec.valid    = 1'b1;
    dec.srca_sel = 2'b11;
    dec.imm_sel  = 3'd6;
    dec.str_ctrl = bus.funct3;
    case (bus.opcode)
      OP_LOAD:   begin dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; dec.srcb_sel = 2'b01; dec.imm_sel = 3'd5; end
      OP_STORE:  begin dec.mem_write = 1'b1; dec.srcb_sel = 2'b01; dec.imm_sel = 3'd2; end
      OP_ALUI: begin
        dec.reg_write = 1'b1;
        dec.srcb_sel  = 2'b01;
        dec.imm_sel   = 3'd0;
        // Only the shift-right-immediate encoding carries funct7[5] (SRAI vs SRLI).
        dec.alu_op    = ALUOP_W'({1'b0, (bus.funct3 == 3'b101) & bus.funct7[5], bus.funct3});
      end
      OP_ALUR: begin
        dec.reg_write = 1'b1;
        case (bus.funct7)
          7'b0000000, 7'b0100000: ;
`ifdef RV32M_EN
          7'b0000001:             m_op = 1'b1;
`endif
          default:                dec.illegal = 1'b1;
        endcase
        dec.alu_op = ALUOP_W'({m_op, bus.funct7[5], bus.funct3});
      end
      OP_LUI:    begin dec.reg_write = 1'b1; dec.srca_sel = 2'b01; dec.srcb_sel = 2'b01; dec.imm_sel = 3'd1; end
      OP_AUIPC:  begin dec.reg_write = 1'b1; dec.srca_sel = 2'b00; dec.srcb_sel = 2'b01; dec.imm_sel = 3'd1; end
      OP_JAL:    begin dec.reg_write = 1'b1; dec.pc_branch = 1'b1; dec.srca_sel = 2'b00; dec.srcb_sel = 2'b10; dec.imm_sel = 3'd4; end
      OP_JALR:   begin dec.reg_write = 1'b1; dec.pc_branch = 1'b1; dec.srca_sel = 2'b00; dec.srcb_sel = 2'b10; dec.imm_sel = 3'd5; end
      OP_BRANCH: begin dec.pc_branch = 1'b1; dec.imm_sel = 3'd3; dec.alu_op = ALUOP_W'({2'b00, bus.funct3}); end
      default:   dec.illegal = 1'b1;
    endcase
    // Illegal ops still travel to EX so the trap logic sees them, but must not commit anything.
    if (dec.illegal) begin
      dec.reg_write  = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.pc_branch  = 1'b0;
    end
  end

`ifdef RV32M_EN
  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            mop_q, mop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mop_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mop_q   <= mop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mop_d   = mop_q;
    case (state_q)
      S_IDLE: if (bus.valid_d && m_op && !bus.stall_i && !bus.flush_i) begin
        state_d = S_BUSY;
        cnt_d   = bus.funct3[2] ? DIV_LOAD : MUL_LOAD;
        mop_d   = dec;
      end
      S_BUSY: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0 && !bus.stall_i) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The M-op is captured on entry, so the held IF/ID contents are not relied upon while busy.
  always_comb begin
    stall_w = 1'b0;
    start_w = 1'b0;
    ex_d    = '0;
    case (state_q)
      S_IDLE: if (bus.valid_d && !bus.stall_i && !bus.flush_i) begin
        if (m_op) begin
          stall_w = 1'b1;
          start_w = 1'b1;
        end else begin
          ex_d = dec;
        end
      end
      S_BUSY: if (!bus.flush_i) begin
        if (cnt_q == '0 && !bus.stall_i) ex_d = mop_q;
        else                             stall_w = 1'b1;
      end
      default: ;
    endcase
  end
`else
  always_comb begin
    stall_w = 1'b0;
    start_w = 1'b0;
    ex_d    = (bus.valid_d && !bus.stall_i && !bus.flush_i) ? dec : '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign bus.stall_d_o    = stall_w;
  assign bus.mdu_start_o  = start_w;
  assign bus.valid_e      = ex_q.valid;
  assign bus.reg_write_e  = ex_q.reg_write;
  assign bus.mem_write_e  = ex_q.mem_write;
  assign bus.mem_to_reg_e = ex_q.mem_to_reg;
  assign bus.pc_branch_e  = ex_q.pc_branch;
  assign bus.srca_sel_e   = ex_q.srca_sel;
  assign bus.srcb_sel_e   = ex_q.srcb_sel;
  assign bus.alu_op_e     = ex_q.alu_op;
  assign bus.imm_sel_e    = ex_q.imm_sel;
  assign bus.str_ctrl_e   = ex_q.str_ctrl;
  assign bus.illegal_e    = ex_q.illegal;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: directed literal cases plus randomized traffic
// compared every cycle against a rule-level reference model (follows RV32M_EN if defined).
module tb_ctrl_decode_pipe;
  localparam int MULC = 4;
  localparam int DIVC = 32;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, ALUI = 7'b0010011,
                         ALUR = 7'b0110011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct packed {
    logic       valid, rw, mw, m2r, pcb;
    logic [1:0] sa, sb;
    logic [4:0] alu;
    logic [2:0] imm, str;
    logic       ill;
  } ebun_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  ctrl_decode_pipe_if #(.ALUOP_W(5)) bus();

  ctrl_decode_pipe #(.ALUOP_W(5), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ebun_t dut_e;
  assign dut_e = {bus.valid_e, bus.reg_write_e, bus.mem_write_e, bus.mem_to_reg_e, bus.pc_branch_e,
                  bus.srca_sel_e, bus.srcb_sel_e, bus.alu_op_e, bus.imm_sel_e, bus.str_ctrl_e,
                  bus.illegal_e};

  // Reference model state: an outstanding M-op and how many cycles it has spent in flight.
  bit    busy = 1'b0;
  int    elapsed = 0;
  int    need = 0;
  ebun_t held = '0;
  ebun_t exp_e = '0;
  logic  last_stall = 1'b0;
  logic  last_start = 1'b0;

  function automatic ebun_t mk(input logic v, rw, mw, m2r, pcb, input logic [1:0] sa, sb,
                               input logic [4:0] alu, input logic [2:0] imm, str, input logic ill);
    mk = {v, rw, mw, m2r, pcb, sa, sb, alu, imm, str, ill};
  endfunction

  function automatic bit is_mop(input logic [6:0] op, input logic [6:0] f7);
    is_mop = M_EN && op == ALUR && f7 == 7'h01;
  endfunction

  function automatic ebun_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    ebun_t e;
    bit known, legal, mop;
    known = op inside {LOAD, STORE, ALUI, ALUR, LUI, AUIPC, JAL, JALR, BR};
    mop   = is_mop(op, f7);
    legal = known && !(op == ALUR && !(f7 == 7'h00 || f7 == 7'h20 || mop));
    e       = '0;
    e.valid = 1'b1;
    e.ill   = !legal;
    e.rw    = legal && (op inside {LOAD, ALUR, ALUI, LUI, AUIPC, JAL, JALR});
    e.mw    = legal && op == STORE;
    e.m2r   = legal && op == LOAD;
    e.pcb   = legal && (op inside {BR, JAL, JALR});
    e.sa    = (op inside {JAL, JALR, AUIPC}) ? 2'b00 : (op == LUI) ? 2'b01 : 2'b11;
    e.sb    = (op inside {JAL, JALR}) ? 2'b10 : (op inside {LOAD, STORE, ALUI, LUI, AUIPC}) ? 2'b01 : 2'b00;
    if (op == ALUR)      e.alu = {mop, f7[5], f3};
    else if (op == ALUI) e.alu = {1'b0, (f3 == 3'b101) && f7[5], f3};
    else if (op == BR)   e.alu = {2'b00, f3};
    if (op == ALUI)                    e.imm = 3'd0;
    else if (op inside {LUI, AUIPC})   e.imm = 3'd1;
    else if (op == STORE)              e.imm = 3'd2;
    else if (op == BR)                 e.imm = 3'd3;
    else if (op == JAL)                e.imm = 3'd4;
    else if (op inside {LOAD, JALR})   e.imm = 3'd5;
    else                               e.imm = 3'd6;
    e.str = f3;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic st, input logic fl);
    ebun_t d, nxt;
    logic  s_exp, st_exp;
    @(negedge clk);
    bus.valid_d = v; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.stall_i = st; bus.flush_i = fl;
    #1;
    d = ref_decode(op, f3, f7);
    nxt = '0; s_exp = 1'b0; st_exp = 1'b0;
    if (busy) begin
      if (fl) busy = 1'b0;
      else if (elapsed >= need && !st) begin nxt = held; busy = 1'b0; end
      else begin st_exp = 1'b1; elapsed++; end
    end else if (v && !st && !fl) begin
      if (is_mop(op, f7)) begin
        st_exp = 1'b1; s_exp = 1'b1; busy = 1'b1; elapsed = 1;
        need = f3[2] ? DIVC : MULC; held = d;
      end else nxt = d;
    end
    last_stall = bus.stall_d_o;
    last_start = bus.mdu_start_o;
    chk("stall_d_o", 32'(bus.stall_d_o), 32'(st_exp));
    chk("mdu_start_o", 32'(bus.mdu_start_o), 32'(s_exp));
    @(posedge clk);
    #1;
    exp_e = nxt;
    chk("e_bundle", 32'(dut_e), 32'(exp_e));
  endtask

  task automatic idle_inputs();
    bus.valid_d = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_e_bundle", 32'(dut_e), 32'd0);
    chk("rst_stall_d_o", 32'(bus.stall_d_o), 32'd0);
    chk("rst_mdu_start_o", 32'(bus.mdu_start_o), 32'd0);
    busy = 1'b0; exp_e = '0; last_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef RV32M_EN
  // Feeds one M-op until it issues or is flushed; returns how many cycles stall_d_o was high.
  task automatic mop_seq(input logic [2:0] f3, input int flush_at, input int hold_at, input int hold_len,
                         output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(1'b1, ALUR, f3, 7'h01, (k >= hold_at && k < hold_at + hold_len), k == flush_at);
      if (k == 0) chk("mop_start_pulse", 32'(last_start), 32'd1);
      if (last_stall) n++;
      if (k > 0 && !last_stall) break;
    end
  endtask
`endif

  task automatic rand_phase(input int ncyc);
    logic [6:0] ops [9];
    logic v, st, fl;
    logic [6:0] op, f7;
    logic [2:0] f3;
    int sel;
    ops = '{LOAD, STORE, ALUI, ALUR, LUI, AUIPC, JAL, JALR, BR};
    v = 1'b0; op = '0; f3 = '0; f7 = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (!last_stall) begin
        v   = ($urandom % 5) != 0;
        sel = $urandom_range(0, 11);
        if (sel < 9)        op = ops[sel];
        else if (sel == 9)  op = ALUR;
        else if (sel == 10) op = 7'($urandom);
        else                op = 7'h7f;
        f3  = 3'($urandom);
        sel = $urandom_range(0, 3);
        f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : 7'($urandom);
      end
      st = ($urandom % 10) == 0;
      fl = ($urandom % 25) == 0;
      cyc(v, op, f3, f7, st, fl);
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    #12;
    chk("reset_e_bundle", 32'(dut_e), 32'd0);
    chk("reset_stall_d_o", 32'(bus.stall_d_o), 32'd0);
    chk("reset_mdu_start_o", 32'(bus.mdu_start_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1'b1, ALUI, 3'b000, 7'h00, 1'b0, 1'b0);
    chk("addi", 32'(dut_e), 32'(mk(1, 1, 0, 0, 0, 2'b11, 2'b01, 5'b00000, 3'd0, 3'd0, 0)));
    cyc(1'b1, STORE, 3'b010, 7'h00, 1'b0, 1'b0);
    chk("sw", 32'(dut_e), 32'(mk(1, 0, 1, 0, 0, 2'b11, 2'b01, 5'b00000, 3'd2, 3'b010, 0)));
    cyc(1'b1, JAL, 3'b000, 7'h00, 1'b0, 1'b0);
    chk("jal", 32'(dut_e), 32'(mk(1, 1, 0, 0, 1, 2'b00, 2'b10, 5'b00000, 3'd4, 3'd0, 0)));
    cyc(1'b1, ALUI, 3'b101, 7'h20, 1'b0, 1'b0);
    chk("srai", 32'(dut_e), 32'(mk(1, 1, 0, 0, 0, 2'b11, 2'b01, 5'b01101, 3'd0, 3'b101, 0)));
    cyc(1'b1, 7'h7f, 3'b000, 7'h00, 1'b0, 1'b0);
    chk("illegal_op", 32'(dut_e), 32'(mk(1, 0, 0, 0, 0, 2'b11, 2'b00, 5'b00000, 3'd6, 3'd0, 1)));
    cyc(1'b1, ALUI, 3'b000, 7'h00, 1'b1, 1'b0);
    chk("stall_bubble", 32'(dut_e), 32'd0);

`ifdef RV32M_EN
    mop_seq(3'b000, -1, -1, 0, n);
    chk("mul_stall_cycles", 32'(n), 32'd4);
    chk("mul_issue", 32'(dut_e), 32'(mk(1, 1, 0, 0, 0, 2'b11, 2'b00, 5'b10000, 3'd6, 3'd0, 0)));
    mop_seq(3'b100, -1, -1, 0, n);
    chk("div_stall_cycles", 32'(n), 32'd32);
    chk("div_issue", 32'(dut_e), 32'(mk(1, 1, 0, 0, 0, 2'b11, 2'b00, 5'b10100, 3'd6, 3'b100, 0)));
    mop_seq(3'b100, 10, -1, 0, n);
    chk("div_flush_stall_cycles", 32'(n), 32'd10);
    chk("div_flush_bubble", 32'(dut_e), 32'd0);
    cyc(1'b1, ALUI, 3'b000, 7'h00, 1'b0, 1'b0);
    chk("after_flush_addi", 32'(dut_e), 32'(mk(1, 1, 0, 0, 0, 2'b11, 2'b01, 5'b00000, 3'd0, 3'd0, 0)));
    mop_seq(3'b100, -1, 32, 3, n);
    chk("div_held_stall_cycles", 32'(n), 32'd35);
    chk("div_held_issue", 32'(dut_e), 32'(mk(1, 1, 0, 0, 0, 2'b11, 2'b00, 5'b10100, 3'd6, 3'b100, 0)));
    cyc(1'b1, ALUR, 3'b000, 7'h01, 1'b0, 1'b0);
    cyc(1'b1, ALUR, 3'b000, 7'h01, 1'b0, 1'b0);
    reset_mid();
`else
    cyc(1'b1, ALUR, 3'b000, 7'h01, 1'b0, 1'b0);
    chk("mul_no_stall", 32'(last_stall), 32'd0);
    chk("mul_illegal", 32'(dut_e), 32'(mk(1, 0, 0, 0, 0, 2'b11, 2'b00, 5'b00000, 3'd6, 3'd0, 1)));
    cyc(1'b1, ALUI, 3'b000, 7'h00, 1'b0, 1'b0);
    reset_mid();
`endif
    cyc(1'b1, ALUI, 3'b000, 7'h00, 1'b0, 1'b0);
    chk("addi_after_reset", 32'(dut_e), 32'(mk(1, 1, 0, 0, 0, 2'b11, 2'b01, 5'b00000, 3'd0, 3'd0, 0)));

    rand_phase(800);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
